// File: rtl/mxv_row_engine_if.sv
// mxv_row_engine_if
// Groups the control, FIFO and result signals of the matrix-vector engine.
//   master : the side driving start/matrix_length/vector and the FIFO head
//   slave  : the engine itself, driving pop and the result/status strobes
// Signals:
//   start, matrix_length, vector     - run request, dimension N, packed vector
//   fifo_data, fifo_empty, pop       - first-word fall-through FIFO read port
//   result, result_valid, result_index - one row dot product per strobe
//   busy, done, length_error         - run status
interface mxv_row_engine_if #(
    parameter int WORD_LENGTH   = 8,
    parameter int RESULT_LENGTH = 2*WORD_LENGTH+3
);
    logic                              start;
    logic [WORD_LENGTH-1:0]            matrix_length;
    logic [WORD_LENGTH*WORD_LENGTH-1:0] vector;
    logic [WORD_LENGTH-1:0]            fifo_data;
    logic                              fifo_empty;
    logic                              pop;
    logic [RESULT_LENGTH-1:0]          result;
    logic                              result_valid;
    logic [WORD_LENGTH-1:0]            result_index;
    logic                              busy;
    logic                              done;
    logic                              length_error;

    modport master (
        output start, matrix_length, vector, fifo_data, fifo_empty,
        input  pop, result, result_valid, result_index, busy, done, length_error
    );

    modport slave (
        input  start, matrix_length, vector, fifo_data, fifo_empty,
        output pop, result, result_valid, result_index, busy, done, length_error
    );
endinterface

// File: rtl/mxv_row_engine.sv
// mxv_row_engine
// Serial single-MAC matrix-vector multiplier. Pops the matrix row-major from a
// first-word fall-through FIFO, multiplies each element by the matching element
// of the latched vector and emits one dot product per row with its row index.
// Ports:
//   clk   - single clock, all state on the rising edge
//   reset - asynchronous, active-low; clears all state
//   bus   - mxv_row_engine_if.slave (control, FIFO read port, results, status)
module mxv_row_engine #(
    parameter int WORD_LENGTH   = 8,
    parameter int RESULT_LENGTH = 2*WORD_LENGTH+3
) (
    input  logic              clk,
    input  logic              reset,
    mxv_row_engine_if.slave   bus
);
    localparam int IDX_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [WORD_LENGTH-1:0] MAX_N = WORD_LENGTH[WORD_LENGTH-1:0];

    typedef enum logic [2:0] {IDLE, LOAD, RUN, EMIT, DONE} state_t;

    state_t                   state;
    state_t                   next_state;
    logic [WORD_LENGTH-1:0]   n_reg;
    logic [WORD_LENGTH-1:0]   vec_mem [WORD_LENGTH];
    logic [RESULT_LENGTH-1:0] acc;
    logic [IDX_W-1:0]         row;
    logic [IDX_W-1:0]         col;
    logic [2*WORD_LENGTH-1:0] product;
    logic [RESULT_LENGTH-1:0] acc_next;
    logic [WORD_LENGTH-1:0]   n_last;
    logic                     n_illegal;
    logic                     last_col;
    logic                     last_row;

    always_comb begin
        product   = {{WORD_LENGTH{1'b0}}, bus.fifo_data} * {{WORD_LENGTH{1'b0}}, vec_mem[col]};
        acc_next  = acc + {{(RESULT_LENGTH-2*WORD_LENGTH){1'b0}}, product};
        n_last    = n_reg - 1'b1;
        n_illegal = (n_reg == '0) || (n_reg > MAX_N);
        last_col  = ({{(WORD_LENGTH-IDX_W){1'b0}}, col} == n_last);
        last_row  = ({{(WORD_LENGTH-IDX_W){1'b0}}, row} == n_last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // pop depends on fifo_empty combinationally so a stalled FIFO never gets popped.
    always_comb begin
        next_state       = state;
        bus.pop          = 1'b0;
        bus.result_valid = 1'b0;
        bus.done         = 1'b0;
        bus.length_error = 1'b0;
        bus.busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (n_illegal) begin
                    bus.length_error = 1'b1;
                    next_state       = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!bus.fifo_empty) begin
                    bus.pop = 1'b1;
                    if (last_col) begin
                        next_state = EMIT;
                    end
                end
            end
            EMIT: begin
                bus.result_valid = 1'b1;
                next_state       = last_row ? DONE : RUN;
            end
            DONE: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The row result is captured together with the last MAC of the row, so
    // result/result_index are already stable during the EMIT strobe cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_reg            <= '0;
            acc              <= '0;
            row              <= '0;
            col              <= '0;
            bus.result       <= '0;
            bus.result_index <= '0;
            for (int i = 0; i < WORD_LENGTH; i++) begin
                vec_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_reg <= bus.matrix_length;
                        for (int i = 0; i < WORD_LENGTH; i++) begin
                            vec_mem[i] <= bus.vector[i*WORD_LENGTH +: WORD_LENGTH];
                        end
                    end
                end
                LOAD: begin
                    acc <= '0;
                    row <= '0;
                    col <= '0;
                end
                RUN: begin
                    if (!bus.fifo_empty) begin
                        acc <= acc_next;
                        if (last_col) begin
                            col              <= '0;
                            bus.result       <= acc_next;
                            bus.result_index <= {{(WORD_LENGTH-IDX_W){1'b0}}, row};
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    acc <= '0;
                    if (!last_row) begin
                        row <= row + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/mxv_row_engine.md
# mxv_row_engine

Matrix-vector multiply engine that sits directly downstream of the UART receive/load stage. Once the matrix is buffered in the FIFO and the vector is captured, it pops matrix elements row-major from the FIFO and multiplies each by the matching vector element. It accumulates one dot product per row and emits each row result with an index for the transmit/result stage. It is a serial single-MAC datapath with one element consumed per cycle.

## Interface

- WORD_LENGTH, 8, width of matrix/vector elements; also the maximum matrix dimension N
- RESULT_LENGTH, 2*WORD_LENGTH+3, accumulator/result width (exact for N ≤ 8 unsigned)

- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  one-cycle request to begin a multiply, sampled only in IDLE
- matrix_length  input  WORD_LENGTH  dimension N, sampled at start
- vector  input  WORD_LENGTH*WORD_LENGTH  packed vector; element j at bits [j*WORD_LENGTH +: WORD_LENGTH], element 0 first received
- fifo_data  input  WORD_LENGTH  FIFO head, first-word fall-through, valid while fifo_empty=0
- fifo_empty  input  1  FIFO has no element
- pop  output  1  consume FIFO head this cycle
- result  output  RESULT_LENGTH  last row dot product, held until next emission
- result_valid  output  1  one-cycle strobe, result/result_index valid
- result_index  output  WORD_LENGTH  row number of result, 0..N-1
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle strobe at end of a multiply
- length_error  output  1  one-cycle strobe, start rejected for illegal N

## Operation

- States: IDLE, LOAD, RUN, EMIT, DONE. All outputs are 0 during reset and in IDLE, except result and result_index, which hold their last values. Their reset value is 0.
- IDLE: when start=1, latch matrix_length into n_reg and vector into vec_reg, then go to LOAD. The upstream may change or clear vector afterwards with no effect.
- LOAD: if n_reg=0 or n_reg>WORD_LENGTH, pulse length_error and go to DONE with no results. Otherwise clear acc, row and col, then go to RUN.
- RUN: pop = ~fifo_empty, combinational from state. On a pop cycle, acc ← acc + fifo_data*vec_reg[col] (unsigned) and col ← col+1. When the consumed element has col=n_reg-1, col wraps to 0 and the FSM goes to EMIT. With fifo_empty=1 the engine stalls: no pop and no state change.
- EMIT: result ← acc, result_index ← row, result_valid=1, acc ← 0. If row=n_reg-1, go to DONE. Otherwise row ← row+1 and go back to RUN. pop=0 in EMIT.
- DONE: done=1 for one cycle, then go to IDLE.
- start is ignored while busy=1; no queuing.
- The engine pops exactly N*N elements per legal run and never pops while fifo_empty=1.
- Reset asserted mid-run aborts immediately: FSM returns to IDLE and any partial row is discarded. FIFO contents are the upstream's responsibility.
- Products are WORD_LENGTH×WORD_LENGTH → 2*WORD_LENGTH bits, zero-extended into acc. No overflow is possible for N ≤ 8 at RESULT_LENGTH default.

## Timing

- start at cycle 0 → LOAD at cycle 1 → first possible pop at cycle 2.
- Without stalls, each row takes N RUN cycles plus 1 EMIT cycle. The first result_valid is at cycle 2+N.
- Total run with no stalls: done at cycle 2+N*(N+1); IDLE at the following cycle, which is the earliest start acceptance.
- Each stall cycle (fifo_empty=1 in RUN) adds exactly one cycle.
- Illegal N: length_error at cycle 1, done at cycle 2, no pop and no result_valid.
- result_valid and done are never simultaneous; done follows the last result_valid by one cycle.

## Test plan

- Matrix rows [1,2],[3,4], vector [5,6], N=2, FIFO pre-filled → result 17 (index 0) at cycle 4, 39 (index 1) at cycle 7, done at cycle 8, 4 pops total.
- Same data with fifo_empty forced high for 3 cycles mid-row 0 → identical results, first result_valid delayed by 3 cycles, no pop while empty.
- N=8, all matrix and vector elements 255 → eight results of 520200 with indices 0..7, 64 pops, done at cycle 74.
- N=1, matrix [7], vector [9] → result 63 at cycle 3, done at cycle 4. A start pulse at cycle 1 is ignored.
- matrix_length=0, then matrix_length=9 → each run gives length_error at cycle 1 and done at cycle 2, with zero pops and no result_valid.
- Reset asserted low during row 1 of an N=3 run → all strobes and pop go to 0 immediately. A fresh run after reset returns correct results from row 0.
